// File: rtl/data_mem_lsu.sv
// Load/store unit with a private byte-addressable data memory for the MEM stage.
// Byte-lane stores, sign/zero-extended loads, range/alignment checks, 2-cycle response.
//
// state | meaning
// CLEAR | zeroing memory one word per cycle, requests refused
// RUN   | accepting one request per cycle
module data_mem_lsu #(
    parameter int ADDR_W         = 15,
    parameter int DEPTH_WORDS    = 2 ** (ADDR_W - 2),
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_unsigned,
    input  logic [1:0]  req_width,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_we,
    output logic [31:0] rsp_data,
    output logic        rsp_misalign,
    output logic        rsp_fault
);

    localparam int WORD_AW = ADDR_W - 2;
    localparam logic [WORD_AW-1:0] LAST_IDX = WORD_AW'(DEPTH_WORDS - 1);

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    localparam logic [1:0] W_WORD = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_BYTE = 2'b10;
    localparam logic [1:0] W_ILL  = 2'b11;

    logic [0:0]         state;
    logic [WORD_AW-1:0] clr_cnt;

    logic               accept;
    logic               req_fault;
    logic               req_misalign;
    logic               store_ok;
    logic [3:0]         st_be;
    logic [31:0]        st_data;

    logic               mem_wen;
    logic [WORD_AW-1:0] mem_idx;
    logic [3:0]         mem_be;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem [DEPTH_WORDS];
    logic [31:0]        rd_data;

    logic               s1_valid;
    logic               s1_we;
    logic               s1_unsigned;
    logic [1:0]         s1_width;
    logic [1:0]         s1_lane;
    logic               s1_misalign;
    logic               s1_fault;

    logic [7:0]         lane_byte;
    logic [15:0]        lane_half;
    logic [31:0]        load_data;

    // Gated by rst_n so the unit never looks ready while reset is held.
    assign req_ready = rst_n && (state == RUN);
    assign accept    = req_valid && req_ready;

    assign req_fault = (req_addr[31:ADDR_W] != '0) || (req_width == W_ILL);

    always_comb begin
        req_misalign = 1'b0;
        case (req_width)
            W_HALF:  req_misalign = req_addr[0];
            W_WORD:  req_misalign = (req_addr[1:0] != 2'b00);
            default: req_misalign = 1'b0;
        endcase
        if (req_fault) begin
            req_misalign = 1'b0;
        end
    end

    assign store_ok = accept && req_we && !req_fault && !req_misalign;

    always_comb begin
        st_be   = 4'b0000;
        st_data = req_wdata;
        case (req_width)
            W_BYTE: begin
                st_be   = 4'b0001 << req_addr[1:0];
                st_data = {4{req_wdata[7:0]}};
            end
            W_HALF: begin
                st_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{req_wdata[15:0]}};
            end
            W_WORD: begin
                st_be   = 4'b1111;
                st_data = req_wdata;
            end
            default: begin
                st_be   = 4'b0000;
                st_data = req_wdata;
            end
        endcase
    end

    always_comb begin
        if (state == CLEAR) begin
            mem_wen   = rst_n;
            mem_idx   = clr_cnt;
            mem_be    = 4'b1111;
            mem_wdata = '0;
        end else begin
            mem_wen   = store_ok;
            mem_idx   = req_addr[ADDR_W-1:2];
            mem_be    = st_be;
            mem_wdata = st_data;
        end
    end

    // Single-port synchronous RAM; contents deliberately carry no reset.
    always_ff @(posedge clk) begin
        if (mem_wen) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
        rd_data <= mem[mem_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_cnt <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + WORD_AW'(1);
                    if (clr_cnt == LAST_IDX) begin
                        state <= RUN;
                    end
                end
                RUN:     state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_we       <= 1'b0;
            s1_unsigned <= 1'b0;
            s1_width    <= 2'b00;
            s1_lane     <= 2'b00;
            s1_misalign <= 1'b0;
            s1_fault    <= 1'b0;
        end else begin
            s1_valid    <= accept;
            s1_we       <= req_we;
            s1_unsigned <= req_unsigned;
            s1_width    <= req_width;
            s1_lane     <= req_addr[1:0];
            s1_misalign <= req_misalign;
            s1_fault    <= req_fault;
        end
    end

    always_comb begin
        case (s1_lane)
            2'd0:    lane_byte = rd_data[7:0];
            2'd1:    lane_byte = rd_data[15:8];
            2'd2:    lane_byte = rd_data[23:16];
            default: lane_byte = rd_data[31:24];
        endcase
        lane_half = s1_lane[1] ? rd_data[31:16] : rd_data[15:0];

        load_data = '0;
        case (s1_width)
            W_WORD:  load_data = rd_data;
            W_HALF:  load_data = {{16{~s1_unsigned & lane_half[15]}}, lane_half};
            W_BYTE:  load_data = {{24{~s1_unsigned & lane_byte[7]}}, lane_byte};
            default: load_data = '0;
        endcase
        if (s1_we || s1_fault || s1_misalign) begin
            load_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid    <= 1'b0;
            rsp_we       <= 1'b0;
            rsp_data     <= '0;
            rsp_misalign <= 1'b0;
            rsp_fault    <= 1'b0;
        end else begin
            rsp_valid    <= s1_valid;
            rsp_we       <= s1_valid & s1_we;
            rsp_data     <= s1_valid ? load_data : '0;
            rsp_misalign <= s1_valid & s1_misalign;
            rsp_fault    <= s1_valid & s1_fault;
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: directed plan cases plus random traffic checked
// against a byte-array reference model with a two-stage expectation pipe.
module tb_data_mem_lsu;

    localparam int ADDR_W = 15;
    localparam int NBYTES = 1 << ADDR_W;
    localparam int NWORDS = NBYTES / 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic        req_unsigned = 1'b0;
    logic [1:0]  req_width = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_we;
    logic [31:0] rsp_data;
    logic        rsp_misalign;
    logic        rsp_fault;

    always #5 clk = ~clk;

    data_mem_lsu #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_unsigned(req_unsigned),
        .req_width(req_width), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_data(rsp_data),
        .rsp_misalign(rsp_misalign), .rsp_fault(rsp_fault)
    );

    typedef struct {
        logic        v;
        logic        we;
        logic [31:0] data;
        logic        mis;
        logic        fault;
    } exp_t;

    logic [7:0]  bmem [NBYTES];
    exp_t        e1, e2;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic        obs_valid, obs_we, obs_mis, obs_fault;
    logic [31:0] obs_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        assert (got === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    function automatic exp_t no_rsp();
        exp_t e;
        e.v = 1'b0; e.we = 1'b0; e.data = '0; e.mis = 1'b0; e.fault = 1'b0;
        return e;
    endfunction

    // Reference: bytes are stored little-endian; an access of n bytes is legal when in range and addr % n == 0.
    task automatic model(input bit we, input bit uns, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] d, output exp_t e);
        int n;
        int base;
        logic [31:0] v;
        e = no_rsp();
        e.v  = 1'b1;
        e.we = we;
        n = (w == 2'b00) ? 4 : (w == 2'b01) ? 2 : 1;
        e.fault = ((a >> ADDR_W) != 0) || (w == 2'b11);
        e.mis   = !e.fault && ((a % n) != 0);
        if (!e.fault && !e.mis) begin
            base = int'(a[ADDR_W-1:0]);
            if (we) begin
                for (int i = 0; i < n; i++) bmem[base + i] = d[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = bmem[base + i];
                if (!uns && n < 4 && v[8*n-1]) begin
                    for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
                end
                e.data = v;
            end
        end
    endtask

    // One cycle: check the response due now, then present the next request.
    task automatic step(input bit v, input bit we, input bit uns, input logic [1:0] w,
                        input logic [31:0] a, input logic [31:0] d);
        exp_t en;
        @(negedge clk);
        obs_valid = rsp_valid; obs_we = rsp_we; obs_data = rsp_data;
        obs_mis = rsp_misalign; obs_fault = rsp_fault;
        check("rsp_valid", obs_valid, e2.v);
        if (e2.v) begin
            check("rsp_we", obs_we, e2.we);
            check("rsp_data", obs_data, e2.data);
            check("rsp_misalign", obs_mis, e2.mis);
            check("rsp_fault", obs_fault, e2.fault);
        end
        e2 = e1;
        req_valid = v; req_we = we; req_unsigned = uns;
        req_width = w; req_addr = a; req_wdata = d;
        en = no_rsp();
        if (v) begin
            check("req_ready", req_ready, 32'd1);
            model(we, uns, w, a, d, en);
        end
        e1 = en;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic load_chk(input string tag, input bit uns, input logic [1:0] w,
                            input logic [31:0] a, input logic [31:0] expv);
        step(1'b1, 1'b0, uns, w, a, 32'h0);
        idle();
        idle();
        check(tag, obs_data, expv);
    endtask

    task automatic reset_and_clear();
        int cnt;
        int viol;
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_rsp_valid", rsp_valid, 32'd0);
            check("rst_req_ready", req_ready, 32'd0);
        end
        check("rst_rsp_we", rsp_we, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_misalign", rsp_misalign, 32'd0);
        check("rst_rsp_fault", rsp_fault, 32'd0);
        // Requests offered during clear must be ignored.
        rst_n = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_width = 2'b00; req_addr = 32'h100;
        #1;
        cnt = 0;
        viol = 0;
        while (!req_ready && cnt < 10000) begin
            cnt++;
            if (rsp_valid) viol++;
            @(negedge clk);
            #1;
        end
        req_valid = 1'b0;
        check("clear_cycles", cnt, NWORDS);
        check("clear_no_rsp", viol, 32'd0);
        for (int i = 0; i < NBYTES; i++) bmem[i] = 8'h00;
        e1 = no_rsp();
        e2 = no_rsp();
    endtask

    initial begin
        bit          r_we, r_uns, r_v;
        logic [1:0]  r_w;
        logic [31:0] r_a;
        int          sel;

        e1 = no_rsp();
        e2 = no_rsp();
        reset_and_clear();

        load_chk("clear_lw_1ffc", 1'b0, 2'b00, 32'h1FFC, 32'h0000_0000);

        step(1'b1, 1'b1, 1'b0, 2'b00, 32'h100, 32'hDEADBEEF);
        step(1'b1, 1'b1, 1'b0, 2'b10, 32'h101, 32'h0000_0055);
        load_chk("sb_lane", 1'b0, 2'b00, 32'h100, 32'hDEAD55EF);
        step(1'b1, 1'b1, 1'b0, 2'b01, 32'h102, 32'h0000_1234);
        load_chk("sh_lane", 1'b0, 2'b00, 32'h100, 32'h123455EF);

        step(1'b1, 1'b1, 1'b0, 2'b00, 32'h100, 32'hDEADBEEF);
        load_chk("lb_103", 1'b0, 2'b10, 32'h103, 32'hFFFFFFDE);
        load_chk("lbu_103", 1'b1, 2'b10, 32'h103, 32'h000000DE);
        load_chk("lh_102", 1'b0, 2'b01, 32'h102, 32'hFFFFDEAD);
        load_chk("lhu_102", 1'b1, 2'b01, 32'h102, 32'h0000DEAD);
        load_chk("lb_100", 1'b0, 2'b10, 32'h100, 32'hFFFFFFEF);

        step(1'b1, 1'b1, 1'b0, 2'b00, 32'h200, 32'h12345678);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h200, 32'h0);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h100, 32'h0);
        check("pipe0_valid", obs_valid, 32'd1);
        check("pipe0_we", obs_we, 32'd1);
        check("pipe0_data", obs_data, 32'h0);
        idle();
        check("pipe1_we", obs_we, 32'd0);
        check("pipe1_data", obs_data, 32'h12345678);
        idle();
        check("pipe2_we", obs_we, 32'd0);
        check("pipe2_data", obs_data, 32'hDEADBEEF);
        idle();

        load_chk("lw_misalign_data", 1'b0, 2'b00, 32'h102, 32'h0);
        check("lw_misalign_flag", obs_mis, 32'd1);
        step(1'b1, 1'b1, 1'b0, 2'b01, 32'h101, 32'h0000AAAA);
        idle();
        idle();
        check("sh_misalign_flag", obs_mis, 32'd1);
        load_chk("sh_misalign_nowrite", 1'b0, 2'b00, 32'h100, 32'hDEADBEEF);
        load_chk("lw_range_data", 1'b0, 2'b00, 32'h8000, 32'h0);
        check("lw_range_fault", obs_fault, 32'd1);
        check("lw_range_nomis", obs_mis, 32'd0);
        load_chk("width3_data", 1'b0, 2'b11, 32'h101, 32'h0);
        check("width3_fault", obs_fault, 32'd1);
        check("width3_nomis", obs_mis, 32'd0);

        for (int k = 0; k < 600; k++) begin
            r_v  = ($urandom_range(0, 7) != 0);
            r_we = $urandom_range(0, 1) == 1;
            r_uns = $urandom_range(0, 1) == 1;
            sel = $urandom_range(0, 15);
            r_w = (sel < 5) ? 2'b00 : (sel < 10) ? 2'b01 : (sel < 15) ? 2'b10 : 2'b11;
            r_a = 32'h400 + $urandom_range(0, 31);
            if ($urandom_range(0, 19) == 0) r_a = r_a | (32'h8000 << $urandom_range(0, 16));
            step(r_v, r_we, r_uns, r_w, r_a, $urandom);
        end
        idle();
        idle();

        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h100, 32'h0);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h404, 32'h0);
        reset_and_clear();
        load_chk("reclear_lw_100", 1'b0, 2'b00, 32'h100, 32'h0);
        load_chk("reclear_lw_200", 1'b0, 2'b00, 32'h200, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
Parametrised load/store unit with its own byte-addressable data memory, for the processor's MEM stage.
- Adds true byte-lane stores (SB/SH preserve the other bytes of the word) and lane-selected loads with correct sign/zero extension.
- Adds misalignment and range checking, and a valid/ready request interface with a fixed 2-cycle response pipeline.
- Adds optional memory zeroing after reset through a small clear state machine.

Parameters:
ADDR_W, 15, byte-address width actually decoded; memory holds 2**ADDR_W bytes
DEPTH_WORDS, 2**(ADDR_W-2), number of 32-bit words (derived, do not override)
CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting requests

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, synchronous, active-low
req_valid  input  1  request present
req_ready  output  1  unit accepts request this cycle
req_we  input  1  1 = store, 0 = load
req_unsigned  input  1  load: 1 = zero-extend, 0 = sign-extend
req_width  input  2  2'b00 word, 2'b01 half, 2'b10 byte, 2'b11 illegal
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  output  1  response valid, one cycle per accepted request
rsp_we  output  1  echo of req_we for this response
rsp_data  output  32  extended load data; 0 for stores, faults and misaligned accesses
rsp_misalign  output  1  access not naturally aligned
rsp_fault  output  1  address out of range or illegal width

Behaviour:
- Accept: req_valid && req_ready. In RUN, req_ready=1 every cycle; no response backpressure.
- Latency: request accepted in cycle N -> rsp_valid=1 in cycle N+2. Fully pipelined, one request per cycle.
- Read timing: synchronous-read RAM registers the address at end of N. Lane select/extend runs in N+1 and is registered into the rsp_* outputs.
- Lane index: byte lane = addr[1:0], half lane = addr[1].
- Store byte enables:
  - SB: 4'b0001<<addr[1:0], data replicated to all lanes.
  - SH: 4'b0011<<(2*addr[1]).
  - SW: 4'b1111.
  - Unselected bytes unchanged.
- Loads: select lane. Byte/half are sign-extended from bit 7/15 when req_unsigned=0 and zero-extended when 1. Word ignores req_unsigned.
- Misalign: half with addr[0]=1, or word with addr[1:0]!=0 -> rsp_misalign=1.
- Fault: any of req_addr[31:ADDR_W] != 0, or req_width=2'b11 -> rsp_fault=1.
- Fault takes priority: rsp_misalign=0 when rsp_fault=1.
- Fault or misalign: no memory write, rsp_data=0, response still issued at N+2.
- Write-then-read: store in N followed by a load of the same word in N+1 returns the new data; no forwarding needed.
- Load and store to the same word in the same cycle cannot occur (single port).
- FSM states: CLEAR, RUN.
  - Reset -> CLEAR if CLEAR_ON_RESET=1, else RUN.
  - CLEAR: req_ready=0. Writes 0 to word index clr_cnt, which increments from 0 each cycle.
  - At clr_cnt=DEPTH_WORDS-1 -> RUN; req_ready=1 the next cycle, so clear takes DEPTH_WORDS cycles.
- Reset values: req_ready=0, rsp_valid=0, rsp_we=0, rsp_data=0, rsp_misalign=0, rsp_fault=0, clr_cnt=0.
- Reset mid-operation: in-flight pipeline entries discarded, with no rsp_valid after the reset cycle. Memory is re-cleared if CLEAR_ON_RESET=1, otherwise contents are retained.
- In CLEAR, req_valid is ignored and produces no response.

Test Plan:
- Clear: CLEAR_ON_RESET=1, ADDR_W=15, release rst_n -> req_ready=0 for exactly 8192 cycles, then 1. LW 0x1FFC -> rsp_data=0x00000000 two cycles later.
- Byte-lane store: SW 0x100=0xDEADBEEF, SB 0x101 wdata=0x00000055, LW 0x100 -> rsp_data=0xDEAD55EF. SH 0x102=0x1234, LW 0x100 -> 0x123455EF.
- Extension: with 0x100=0xDEADBEEF:
  - LB 0x103 -> 0xFFFFFFDE; LBU 0x103 -> 0x000000DE.
  - LH 0x102 -> 0xFFFFDEAD; LHU 0x102 -> 0x0000DEAD.
  - LB 0x100 -> 0xFFFFFFEF.
- Pipelining: SW 0x200=0x12345678 in N, LW 0x200 in N+1, LW 0x100 in N+2 -> rsp_valid high N+2..N+4 and rsp_data 0, 0x12345678, prior value in order. rsp_we = 1, 0, 0.
- Errors:
  - LW 0x102 -> rsp_misalign=1, rsp_data=0.
  - SH 0x101 -> rsp_misalign=1 and memory unchanged (verified by LW 0x100).
  - LW 0x8000 -> rsp_fault=1, rsp_misalign=0.
  - width 2'b11 -> rsp_fault=1.
- Reset mid-stream: two loads accepted, rst_n=0 the next cycle -> rsp_valid stays 0 and clear restarts with req_ready=0.
